// File: rtl/ram_console_pkg.sv
// ram_console_pkg
// Shared definitions for the ram_* bus data-side slave:
//   - console register byte offsets relative to CON_BASE
//   - STATUS register bit positions
//   - transmitter FSM state encoding
package ram_console_pkg;

    // Console register byte offsets (word aligned)
    localparam logic [3:0] STATUS_OFS = 4'h0;
    localparam logic [3:0] TXDATA_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    // STATUS register bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_LEVEL = 8;   // level field is FIFO_AW+1 bits wide from here

    // CTRL register bit positions
    localparam int CTRL_IE = 0;

    // Serial transmitter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/console_uart_tx.sv
// console_uart_tx
// 8N1 serial transmitter fed from the console TX FIFO through a valid/ready
// pop interface. One start bit, eight data bits LSB first, one stop bit,
// each held for CLK_DIV clocks.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   fifo_valid          FIFO has a byte at its head
//   fifo_data[7:0]      byte at the FIFO head
//   fifo_ready          transmitter takes the head byte this cycle
//   uart_tx             serial line, idle high
//   tx_busy             a frame is in progress
module console_uart_tx
    import ram_console_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       fifo_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    tx_state_e        state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (div_cnt == DIV_LAST);
    assign tx_busy = (state != IDLE);

    // Next state, pop handshake and line level. The line is decoded from the
    // state so that an asynchronous reset returns it high immediately.
    always_comb begin
        state_nxt  = state;
        fifo_ready = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            IDLE: begin
                fifo_ready = 1'b1;
                if (fifo_valid) state_nxt = START;
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                uart_tx = shreg[bit_cnt];
                if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, divider (restarts every bit) and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || bit_end) div_cnt <= '0;
            else                          div_cnt <= div_cnt + DIV_W'(1);
            if (state == START)             bit_cnt <= '0;
            else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Data path: shift register is loaded on pop and needs no reset
    always_ff @(posedge clk) begin
        if (fifo_ready && fifo_valid) shreg <= fifo_data;
    end

endmodule

// File: rtl/ram_console_slave.sv
// ram_console_slave
// Data-side slave for the core's ram_* bus: a word RAM with byte-lane writes
// and a console peripheral (STATUS / TXDATA / CTRL, TX FIFO, 8N1 UART).
// Accesses that hit neither region raise a one-cycle ram_abort.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   ram_cen          request this cycle
//   ram_wen          1 = write, 0 = read
//   ram_flag[3:0]    byte-lane write enables
//   ram_addr[31:0]   byte address (bits [1:0] ignored)
//   ram_wdata[31:0]  write data
//   ram_rdata[31:0]  registered read data, held until the next read
//   ram_abort        pulse one cycle after an unmapped access
//   uart_tx          serial output, idle high
//   con_irq          TX FIFO empty, transmitter idle and CTRL.ie set
module ram_console_slave
    import ram_console_pkg::*;
#(
    parameter int          RAM_AW     = 9,
    parameter logic [3:0]  RAM_REGION = 4'h4,
    parameter logic [31:0] CON_BASE   = 32'hE000_0000,
    parameter int          FIFO_AW    = 4,
    parameter int          CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_cen,
    input  logic        ram_wen,
    input  logic [3:0]  ram_flag,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic        ram_abort,
    output logic        uart_tx,
    output logic        con_irq
);

    localparam int RAM_WORDS  = 2 ** RAM_AW;
    localparam int FIFO_DEPTH = 2 ** FIFO_AW;

    // ---------------- decode ----------------
    logic              ram_hit, con_hit;
    logic [3:0]        con_ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic              acc_rd, acc_wr;
    logic              sel_status, sel_txdata, sel_ctrl;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^ram_addr[1:0];
    assign acc_rd  = ram_cen & ~ram_wen;
    assign acc_wr  = ram_cen &  ram_wen;
    assign ram_idx = ram_addr[RAM_AW+1:2];
    assign con_ofs = {ram_addr[3:2], 2'b00};
    assign ram_hit = (ram_addr[31:28] == RAM_REGION);
    // RAM decode wins if the two regions were ever configured to overlap
    assign con_hit = ~ram_hit && (ram_addr[31:4] == CON_BASE[31:4])
                     && (ram_addr[3:2] != 2'b11);

    assign sel_status = con_hit && (con_ofs == STATUS_OFS);
    assign sel_txdata = con_hit && (con_ofs == TXDATA_OFS);
    assign sel_ctrl   = con_hit && (con_ofs == CTRL_OFS);

    // ---------------- RAM ----------------
    logic [31:0] mem [0:RAM_WORDS-1];

    always_ff @(posedge clk) begin
        if (acc_wr && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_flag[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- TX FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, level;
    logic             empty, full, push_req, push, pop, tx_ready, tx_busy;
    logic             ovf, ie;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW])
                   && (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign push_req = acc_wr & sel_txdata & ram_flag[0];
    assign pop      = tx_ready & ~empty;
    // A push into a full FIFO still fits when the head leaves this cycle
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= ram_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            ie     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (acc_wr && sel_status)             ovf <= 1'b0;
            else if (push_req && full && !pop)    ovf <= 1'b1;
            if (acc_wr && sel_ctrl && ram_flag[0]) ie <= ram_wdata[CTRL_IE];
        end
    end

    console_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_valid (~empty),
        .fifo_data  (fifo_mem[rd_ptr[FIFO_AW-1:0]]),
        .fifo_ready (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy)
    );

    // ---------------- read mux ----------------
    logic [31:0] status_word, rd_word;

    always_comb begin
        status_word                         = '0;
        status_word[ST_FULL]                = full;
        status_word[ST_EMPTY]               = empty;
        status_word[ST_OVF]                 = ovf;
        status_word[ST_BUSY]                = tx_busy;
        status_word[ST_LEVEL +: FIFO_AW+1]  = level;
    end

    // Unmapped reads and TXDATA reads fall through to zero
    always_comb begin
        rd_word = '0;
        if (ram_hit)         rd_word = mem[ram_idx];
        else if (sel_status) rd_word = status_word;
        else if (sel_ctrl)   rd_word[CTRL_IE] = ie;
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rdata <= '0;
            ram_abort <= 1'b0;
            con_irq   <= 1'b0;
        end else begin
            ram_abort <= ram_cen & ~ram_hit & ~con_hit;
            if (acc_rd) ram_rdata <= rd_word;
            con_irq <= ie & empty & ~tx_busy;
        end
    end

endmodule

// File: tb/tb_ram_console_slave.sv
module tb_ram_console_slave;

    localparam int CLK_DIV = 16;
    localparam logic [31:0] STA = 32'hE000_0000;
    localparam logic [31:0] TXD = 32'hE000_0004;
    localparam logic [31:0] CTL = 32'hE000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_cen = 1'b0;
    logic        ram_wen = 1'b0;
    logic [3:0]  ram_flag = 4'h0;
    logic [31:0] ram_addr = 32'h0;
    logic [31:0] ram_wdata = 32'h0;
    logic [31:0] ram_rdata;
    logic        ram_abort;
    logic        uart_tx;
    logic        con_irq;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        abort;
        logic        is_rd;
        string       nm;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        wen;
        logic [3:0]  flag;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ab;
    } vec_t;
    vec_t vt[$];

    ram_console_slave #(
        .RAM_AW     (9),
        .RAM_REGION (4'h4),
        .CON_BASE   (32'hE000_0000),
        .FIFO_AW    (4),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_flag  (ram_flag),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_abort (ram_abort),
        .uart_tx   (uart_tx),
        .con_irq   (con_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One bus request: driven on the falling edge, sampled by the next rising
    // edge, results compared 1 time unit after that edge.
    task automatic access(input logic wen, input logic [3:0] flag, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_ab, input string nm);
        sb_t e;
        @(negedge clk);
        ram_cen = 1'b1; ram_wen = wen; ram_flag = flag; ram_addr = addr; ram_wdata = wdata;
        e.rdata = exp_rd; e.abort = exp_ab; e.is_rd = ~wen; e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        ram_cen = 1'b0; ram_wen = 1'b0; ram_flag = 4'h0;
        e = sb.pop_front();
        chk({e.nm, "_abort"}, {31'h0, ram_abort}, {31'h0, e.abort});
        if (e.is_rd) chk({e.nm, "_rdata"}, ram_rdata, e.rdata);
    endtask

    task automatic wait_start(input string nm);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) begin
                seen = 1;
                break;
            end
        end
        chk({nm, "_start_seen"}, {31'h0, seen}, 32'h1);
    endtask

    // Push one byte, then compare every cycle of the 10*CLK_DIV frame.
    task automatic send_check(input logic [7:0] b, input string nm);
        logic [9:0] fr;
        int errs = 0;
        fr = {1'b1, b, 1'b0};
        access(1'b1, 4'h1, TXD, {24'h0, b}, 32'h0, 1'b0, {nm, "_push"});
        wait_start(nm);
        for (int c = 1; c < 10 * CLK_DIV; c++) begin
            @(posedge clk); #1;
            if (uart_tx !== fr[c / CLK_DIV]) errs++;
        end
        chk({nm, "_frame_bad_cycles"}, 32'(errs), 32'h0);
        @(posedge clk); #1;
        chk({nm, "_idle_line"}, {31'h0, uart_tx}, 32'h1);
        access(1'b0, 4'h0, STA, 32'h0, 32'h2, 1'b0, {nm, "_status_after"});
    endtask

    initial begin
        int n;
        bit back;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", ram_rdata, 32'h0);
        chk("rst_abort", {31'h0, ram_abort}, 32'h0);
        chk("rst_uart", {31'h0, uart_tx}, 32'h1);
        chk("rst_irq", {31'h0, con_irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven bus vectors ----------------
        vt.push_back('{1'b1, 4'hF, 32'h4000_0010, 32'hAABB_CCDD, 32'h0,         1'b0});
        vt.push_back('{1'b1, 4'h5, 32'h4000_0010, 32'h1122_3344, 32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h4000_0010, 32'h0,         32'hAA22_CC44, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h4000_0810, 32'h0,         32'hAA22_CC44, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h3000_0000, 32'h0,         32'h0,         1'b1});
        vt.push_back('{1'b1, 4'hF, 32'h4000_0020, 32'h1234_5678, 32'h0,         1'b0});
        vt.push_back('{1'b1, 4'h0, 32'h4000_0020, 32'hFFFF_FFFF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, 32'h4000_0023, 32'h0,         32'h1234_5678, 1'b0});
        vt.push_back('{1'b1, 4'hF, 32'h5000_0020, 32'hDEAD_BEEF, 32'h0,         1'b1});
        vt.push_back('{1'b0, 4'h0, 32'h4000_0020, 32'h0,         32'h1234_5678, 1'b0});
        vt.push_back('{1'b0, 4'h0, 32'hE000_000C, 32'h0,         32'h0,         1'b1});
        vt.push_back('{1'b0, 4'h0, 32'hE000_0010, 32'h0,         32'h0,         1'b1});
        vt.push_back('{1'b0, 4'h0, TXD,           32'h0,         32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, STA,           32'h0,         32'h2,         1'b0});
        vt.push_back('{1'b1, 4'hE, CTL,           32'hFFFF_FFFF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, CTL,           32'h0,         32'h0,         1'b0});
        vt.push_back('{1'b1, 4'h1, CTL,           32'hFFFF_FFFF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, CTL,           32'h0,         32'h1,         1'b0});
        vt.push_back('{1'b1, 4'h1, CTL,           32'h0,         32'h0,         1'b0});
        vt.push_back('{1'b0, 4'h0, CTL,           32'h0,         32'h0,         1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            access(vt[i].wen, vt[i].flag, vt[i].addr, vt[i].wdata,
                   vt[i].exp_rd, vt[i].exp_ab, $sformatf("vec%0d", i));
        end
        // abort lasts exactly one cycle
        access(1'b0, 4'h0, 32'h3000_0000, 32'h0, 32'h0, 1'b1, "abort_pulse");
        @(posedge clk); #1;
        chk("abort_one_cycle", {31'h0, ram_abort}, 32'h0);

        // ---------------- serial frame 0x48 ----------------
        send_check(8'h48, "frame48");

        // ---------------- interrupt ----------------
        access(1'b1, 4'h1, CTL, 32'h1, 32'h0, 1'b0, "irq_ctrl_on");
        @(posedge clk); #1;
        chk("irq_high_idle", {31'h0, con_irq}, 32'h1);
        access(1'b1, 4'h1, TXD, 32'h5A, 32'h0, 1'b0, "irq_push");
        @(posedge clk); #1;
        chk("irq_drop", {31'h0, con_irq}, 32'h0);
        back = 0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (con_irq === 1'b1) begin
                back = 1;
                n = i;
                break;
            end
        end
        chk("irq_returns", {31'h0, back}, 32'h1);
        chk("irq_return_time", {31'h0, (n >= 155 && n <= 170)}, 32'h1);
        access(1'b1, 4'h1, CTL, 32'h0, 32'h0, 1'b0, "irq_ctrl_off");
        @(posedge clk); #1;
        chk("irq_off", {31'h0, con_irq}, 32'h0);

        // ---------------- reset in the middle of a data bit ----------------
        access(1'b1, 4'h1, TXD, 32'hA5, 32'h0, 1'b0, "rst_push0");
        wait_start("rst_frame");
        access(1'b1, 4'h1, TXD, 32'h11, 32'h0, 1'b0, "rst_push1");
        access(1'b1, 4'h1, TXD, 32'h22, 32'h0, 1'b0, "rst_push2");
        access(1'b1, 4'h1, TXD, 32'h33, 32'h0, 1'b0, "rst_push3");
        repeat (37) begin
            @(posedge clk); #1;
        end
        // frame offset 40: data bit 1 of 0xA5, which is 0
        chk("rst_pre_line", {31'h0, uart_tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_line", {31'h0, uart_tx}, 32'h1);
        chk("rst_async_irq", {31'h0, con_irq}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 4'h0, STA, 32'h0, 32'h2, 1'b0, "rst_status_level0");
        send_check(8'h48, "frame_after_rst");

        // ---------------- FIFO full / overflow ----------------
        access(1'b1, 4'h1, TXD, 32'h01, 32'h0, 1'b0, "ovf_first");
        repeat (2) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            access(1'b1, 4'h1, TXD, 32'(i + 8'h30), 32'h0, 1'b0, $sformatf("ovf_push%0d", i));
        end
        // level 16, busy, overflow, full
        access(1'b0, 4'h0, STA, 32'h0, 32'h0000_100D, 1'b0, "ovf_status");
        access(1'b1, 4'h0, STA, 32'h0, 32'h0, 1'b0, "ovf_clear");
        access(1'b0, 4'h0, STA, 32'h0, 32'h0000_1009, 1'b0, "ovf_status_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait above never returns
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_console_slave.md
Name: ram_console_slave

Overview:
Synthesizable data-side slave for the ARM9-compatible core's ram_* bus, which replaces the behavioural RAM/console model.
- Provides a parametrised word RAM with byte-lane writes.
- Provides a console peripheral: status/control registers, a TX FIFO and an 8N1 serial transmitter on uart_tx.
- Any access outside both regions raises ram_abort.

Parameters:
RAM_AW, 9, RAM word-address bits (2^RAM_AW words, default 512 x 32).
RAM_REGION, 4'h4, value of ram_addr[31:28] that selects RAM.
CON_BASE, 32'hE000_0000, console register base (3 words: +0 STATUS, +4 TXDATA, +8 CTRL).
FIFO_AW, 4, TX FIFO depth = 2^FIFO_AW entries of 8 bits.
CLK_DIV, 16, clocks per UART bit (>=2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
ram_cen  in  1  access request this cycle.
ram_wen  in  1  1=write, 0=read (qualified by ram_cen).
ram_flag  in  4  byte-lane write enables, bit n = ram_wdata[8n+7:8n].
ram_addr  in  32  byte address; bits[1:0] ignored.
ram_wdata  in  32  write data.
ram_rdata  out  32  registered read data.
ram_abort  out  1  one-cycle pulse for an unmapped access.
uart_tx  out  1  serial output, idle high.
con_irq  out  1  level interrupt: TX FIFO empty and CTRL.ie set.

Behaviour:
- Reset values: ram_rdata=0, ram_abort=0, uart_tx=1, con_irq=0, FIFO empty, CTRL=0, overflow sticky=0. RAM contents are not reset.
- Decode, in the request cycle:
  - RAM hit: ram_addr[31:28]==RAM_REGION. Word index = ram_addr[RAM_AW+1:2]. Higher address bits alias.
  - Console hit: ram_addr[31:4]==CON_BASE[31:4] and word offset 0..2. Offset 3 is unmapped.
  - Anything else is unmapped.
- Read latency is 1 cycle. ram_rdata updates on the clock edge that samples ram_cen&~ram_wen and holds until the next read.
  - RAM read returns the stored word.
  - A RAM read and write never coincide: the bus carries one request per cycle.
- RAM write applies only the lanes whose ram_flag bit is set; other lanes keep their value. ram_flag=0 is a legal no-op.
- STATUS read:
  - bit0 = full.
  - bit1 = empty.
  - bit2 = overflow sticky.
  - bit3 = tx_busy (shifter active).
  - bits[FIFO_AW+8:8] = FIFO level (0..2^FIFO_AW).
  - All other bits 0.
- STATUS write: any write clears the overflow sticky bit. Other bits are read-only.
- TXDATA write with ram_flag[0]=1 pushes ram_wdata[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow sets.
  - TXDATA reads return 0.
- CTRL: bit0 = ie; all other bits read 0. Byte lane 0 must be enabled for a CTRL write to take effect.
- Unmapped access, read or write: ram_abort=1 for exactly the next cycle and ram_rdata=0 for a read. No state changes.
- Push and pop in the same cycle are both accepted and the level is unchanged, including when the FIFO is full. Push to an empty FIFO while the shifter is idle is popped no earlier than the next cycle.
- Pointers are FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1). full/empty come from the MSB compare.
- Transmitter FSM:
  - IDLE: when the FIFO is not empty, pop and go to START.
  - START: drive 0 for CLK_DIV cycles.
  - DATA: send bits 0..7, LSB first, CLK_DIV cycles each.
  - STOP: drive 1 for CLK_DIV cycles, then return to IDLE.
  - Each frame is therefore 10*CLK_DIV cycles.
  - Back-to-back bytes have no idle gap beyond one clock.
  - The divider counter restarts at each bit.
- con_irq is registered: con_irq = ie & empty & ~tx_busy.
- When rst_n asserts mid-frame, uart_tx goes to 1 immediately (asynchronous), the FIFO empties and the FSM returns to IDLE.

Decomposition:
- Shared package ram_console_pkg holds:
  - register offsets STATUS_OFS=0, TXDATA_OFS=4, CTRL_OFS=8;
  - STATUS bit positions;
  - the tx FSM state enum (IDLE, START, DATA, STOP).
- One natural sub-module: console_uart_tx, containing the FSM, the bit counter and the divider. It uses a valid/ready pop interface to the FIFO.
- The FIFO and the RAM stay inline in the top.

Test Plan:
- Write 0x4000_0010 data 0xAABBCCDD flag 4'b1111, then flag 4'b0101 data 0x11223344, then read -> ram_rdata=0xAA22CC44 one cycle after the read request.
- Read 0x4000_0810 with RAM_AW=9 -> aliases to word 4 and returns the same value as 0x4000_0010; read 0x3000_0000 -> ram_abort high for one cycle, ram_rdata=0.
- Push 0x48 to TXDATA, CLK_DIV=16 -> uart_tx low for 16 cycles, then bits 0,0,0,1,0,0,1,0, then high; the frame lasts 160 cycles.
- Push 17 bytes quickly with FIFO_AW=4 and the transmitter stalled in its first frame -> STATUS shows full=1 and overflow=1; a STATUS write then clears overflow.
- CTRL=1 with the FIFO idle -> con_irq=1; a TXDATA push drops con_irq on the next cycle; con_irq returns after the stop bit.
- Assert rst_n=0 mid-DATA bit -> uart_tx=1 and STATUS level=0 without waiting for a clock edge; after release the first push transmits normally.
